// File: rtl/uart_loader.sv
// uart_loader: boot loader that turns the uart_rx byte stream into memory writes.
// Frame: 4-byte little-endian word count, then count*4 payload bytes packed
// little-endian into 32-bit words, one valid/ready write per word at
// consecutive word addresses starting at BASE_ADDR. The core is held in
// reset (cpu_resetn low) until the whole image has been written.
// Optional feature macro: UART_LOADER_CHECKSUM_EN -- adds a trailing XOR
// checksum byte that must match every payload byte XORed together.
module uart_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_resetn,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word index only has to reach MAX_WORDS, so it is kept narrow.
    localparam int                    WORD_W = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0]           MAX_W  = 32'(MAX_WORDS);

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_DATA   = 3'd1,
        S_WRITE  = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_DATA   = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`endif

    // Registered state
    state_t                r_state;
    logic [1:0]            r_byte_idx;
    logic [31:0]           r_count;
    logic [31:0]           r_word_buf;
    logic [WORD_W-1:0]     r_word_idx;
    logic                  r_mem_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_resetn;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    // Next-state values
    state_t                w_state_next;
    logic [1:0]            w_byte_idx_next;
    logic [31:0]           w_count_next;
    logic [31:0]           w_word_buf_next;
    logic [WORD_W-1:0]     w_word_idx_next;
    logic                  w_mem_valid_next;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [31:0]           w_mem_wdata_next;
    logic                  w_cpu_resetn_next;
    logic                  w_busy_next;
    logic                  w_done_next;
    logic                  w_error_next;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
    logic [7:0]            w_csum_next;
`endif

    // Helpers: the incoming byte dropped into lane r_byte_idx
    logic [31:0]           w_count_ins;
    logic [31:0]           w_word_ins;
    logic [WORD_W-1:0]     w_word_inc;
    logic                  w_last_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_count_ins[8*gi +: 8] = (r_byte_idx == 2'(gi)) ? rx_data : r_count[8*gi +: 8];
            assign w_word_ins[8*gi +: 8]  = (r_byte_idx == 2'(gi)) ? rx_data : r_word_buf[8*gi +: 8];
        end
    endgenerate

    assign w_word_inc  = r_word_idx + WORD_W'(1);
    assign w_last_word = (32'(w_word_inc) == r_count);

    // State register and all registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_HEADER;
            r_byte_idx   <= 2'd0;
            r_count      <= 32'd0;
            r_word_buf   <= 32'd0;
            r_word_idx   <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= BASE;
            r_mem_wdata  <= 32'd0;
            r_cpu_resetn <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_byte_idx   <= w_byte_idx_next;
            r_count      <= w_count_next;
            r_word_buf   <= w_word_buf_next;
            r_word_idx   <= w_word_idx_next;
            r_mem_valid  <= w_mem_valid_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_cpu_resetn <= w_cpu_resetn_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_error      <= w_error_next;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum       <= w_csum_next;
`endif
        end
    end

    // Next-state and next-output logic; every field holds unless changed below
    always_comb begin
        w_state_next      = r_state;
        w_byte_idx_next   = r_byte_idx;
        w_count_next      = r_count;
        w_word_buf_next   = r_word_buf;
        w_word_idx_next   = r_word_idx;
        w_mem_valid_next  = r_mem_valid;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_cpu_resetn_next = r_cpu_resetn;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_error_next      = r_error;
`ifdef UART_LOADER_CHECKSUM_EN
        w_csum_next       = r_csum;
`endif

        case (r_state)
            S_HEADER: begin
                if (rx_ready) begin
                    w_count_next    = w_count_ins;
                    w_byte_idx_next = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        if (w_count_ins == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            // Empty image still carries a checksum byte (0x00).
                            w_state_next = S_CHECK;
`else
                            w_state_next      = S_DONE;
                            w_done_next       = 1'b1;
                            w_busy_next       = 1'b0;
                            w_cpu_resetn_next = 1'b1;
`endif
                        end else if (w_count_ins > MAX_W) begin
                            w_state_next      = S_ERR;
                            w_error_next      = 1'b1;
                            w_busy_next       = 1'b0;
                            w_cpu_resetn_next = 1'b0;
                            w_mem_valid_next  = 1'b0;
                        end else begin
                            w_state_next = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (rx_ready) begin
                    w_word_buf_next = w_word_ins;
                    w_byte_idx_next = r_byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    w_csum_next     = r_csum ^ rx_data;
`endif
                    if (r_byte_idx == 2'd3) begin
                        w_mem_valid_next = 1'b1;
                        w_mem_wdata_next = w_word_ins;
                        w_state_next     = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                if (rx_ready) begin
                    // A byte arriving while a word is still pending is an overrun.
                    w_state_next      = S_ERR;
                    w_error_next      = 1'b1;
                    w_busy_next       = 1'b0;
                    w_cpu_resetn_next = 1'b0;
                    w_mem_valid_next  = 1'b0;
                end else if (mem_ready) begin
                    w_mem_valid_next = 1'b0;
                    w_word_idx_next  = w_word_inc;
                    w_mem_addr_next  = r_mem_addr + ADDR_WIDTH'(4);
                    if (w_last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next      = S_DONE;
                        w_done_next       = 1'b1;
                        w_busy_next       = 1'b0;
                        w_cpu_resetn_next = 1'b1;
`endif
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end

`ifdef UART_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_ready) begin
                    if (rx_data == r_csum) begin
                        w_state_next      = S_DONE;
                        w_done_next       = 1'b1;
                        w_busy_next       = 1'b0;
                        w_cpu_resetn_next = 1'b1;
                    end else begin
                        w_state_next      = S_ERR;
                        w_error_next      = 1'b1;
                        w_busy_next       = 1'b0;
                        w_cpu_resetn_next = 1'b0;
                        w_mem_valid_next  = 1'b0;
                    end
                end
            end
`endif

            S_DONE: begin
                // Terminal: only reset leaves.
            end

            S_ERR: begin
                // Terminal: only reset leaves.
            end

            default: begin
                w_state_next      = S_ERR;
                w_error_next      = 1'b1;
                w_busy_next       = 1'b0;
                w_cpu_resetn_next = 1'b0;
                w_mem_valid_next  = 1'b0;
            end
        endcase
    end

    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_resetn = r_cpu_resetn;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
